// File: rtl/dma_resp_mem.sv
// DMA responder for the openMSP430 DMA master interface: local word memory,
// programmable wait states, access statistics. Define DMA_RESP_TRACE_EN for LDATA.
module dma_resp_mem #(
  parameter logic [14:0] BASE_ADDR = 15'h0190,
  parameter int unsigned DEC_WD    = 4,
  parameter logic [14:0] MEM_BASE  = 15'h4000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        dma_en,
  input  logic [14:0] dma_addr,
  input  logic [1:0]  dma_we,
  input  logic [15:0] dma_din,
  output logic        dma_ready,
  output logic [15:0] dma_dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEC_WD-2:0] IDX_CTRL  = (DEC_WD-1)'(0);
  localparam logic [DEC_WD-2:0] IDX_STAT  = (DEC_WD-1)'(1);
  localparam logic [DEC_WD-2:0] IDX_CNT   = (DEC_WD-1)'(2);
  localparam logic [DEC_WD-2:0] IDX_LADDR = (DEC_WD-1)'(3);
  localparam logic [DEC_WD-2:0] IDX_LDATA = (DEC_WD-1)'(4);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        en_q;
  logic [3:0]  wait_q;
  logic        oor_q;
  logic [15:0] cnt_q;
  logic [15:0] laddr_q;
  logic [15:0] dout_q;
  logic [15:0] mem [DEPTH];

  // Peripheral register decode
  logic                reg_sel, reg_rd;
  logic [DEC_WD-2:0]   reg_idx;
  logic                wr_ctrl, wr_stat, wr_cnt;

  assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx = per_addr[DEC_WD-2:0];
  assign reg_rd  = reg_sel & (per_we == 2'b00);
  assign wr_ctrl = reg_sel & (reg_idx == IDX_CTRL) & per_we[0];
  assign wr_stat = reg_sel & (reg_idx == IDX_STAT) & per_we[0];
  assign wr_cnt  = reg_sel & (reg_idx == IDX_CNT) & (per_we != 2'b00);

  // DMA window decode
  logic [14:0]   mem_off;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          dma_acc;
  logic [15:0]   rd_word;

  assign mem_off  = dma_addr - MEM_BASE;
  assign mem_idx  = mem_off[AW-1:0];
  assign in_range = ({1'b0, dma_addr} >= {1'b0, MEM_BASE}) &&
                    ({1'b0, dma_addr} < ({1'b0, MEM_BASE} + 16'(DEPTH)));
  assign rd_word  = in_range ? mem[mem_idx] : '0;
  assign dma_acc  = dma_en & dma_ready;

  logic unused_bits;
  assign unused_bits = ^{per_din[15:8], per_din[3:1], mem_off[14:AW]};

  // FSM: state register
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (en_q && dma_en && (wait_q != 4'd0)) begin
          state_d = S_WAIT;
          wcnt_d  = 4'd1;
        end
      end
      S_WAIT: begin
        // >= lets a WAIT lowered mid-request release the initiator at once
        if (!en_q || !dma_en || (wcnt_q >= wait_q)) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q != '1) begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    dma_ready = 1'b0;
    if (!puc_rst && en_q && dma_en) begin
      case (state_q)
        S_IDLE:  dma_ready = (wait_q == 4'd0);
        S_WAIT:  dma_ready = (wcnt_q >= wait_q);
        default: dma_ready = 1'b0;
      endcase
    end
  end

  // Configuration and statistics
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      en_q    <= 1'b0;
      wait_q  <= '0;
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      laddr_q <= '0;
      dout_q  <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= per_din[0];
        wait_q <= per_din[7:4];
      end
      if (dma_acc && !in_range) oor_q <= 1'b1;
      else if (wr_stat && per_din[0]) oor_q <= 1'b0;
      if (wr_cnt) cnt_q <= '0;
      else if (dma_acc && (cnt_q != '1)) cnt_q <= cnt_q + 16'd1;
      if (dma_acc) laddr_q <= {dma_addr, 1'b0};
      if (dma_acc && (dma_we == 2'b00)) dout_q <= rd_word;
    end
  end

  always_ff @(posedge mclk) begin
    if (dma_acc && in_range) begin
      if (dma_we[0]) mem[mem_idx][7:0]  <= dma_din[7:0];
      if (dma_we[1]) mem[mem_idx][15:8] <= dma_din[15:8];
    end
  end

  assign dma_dout = dout_q;

`ifdef DMA_RESP_TRACE_EN
  logic [15:0] ldata_q;
  always_ff @(posedge mclk) begin
    if (puc_rst) ldata_q <= '0;
    else if (dma_acc) ldata_q <= (dma_we != 2'b00) ? dma_din : rd_word;
  end
`else
  logic [15:0] ldata_q;
  assign ldata_q = '0;
`endif

  always_comb begin
    per_dout = '0;
    if (reg_rd) begin
      case (reg_idx)
        IDX_CTRL:  per_dout = {8'h00, wait_q, 3'b000, en_q};
        IDX_STAT:  per_dout = {14'h0000, (state_q != S_IDLE), oor_q};
        IDX_CNT:   per_dout = cnt_q;
        IDX_LADDR: per_dout = laddr_q;
        IDX_LDATA: per_dout = ldata_q;
        default:   per_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_resp_mem.sv
// Scoreboard bench for dma_resp_mem: stimulus queues expected register and DMA
// read data, a negedge monitor pops and compares whenever the DUT presents it.
module tb_dma_resp_mem;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        dma_en;
  logic [14:0] dma_addr;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic        dma_ready;
  logic [15:0] dma_dout;

  dma_resp_mem #(
    .BASE_ADDR(15'h0190),
    .DEC_WD   (4),
    .MEM_BASE (15'h4000),
    .DEPTH    (64)
  ) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .dma_en   (dma_en),
    .dma_addr (dma_addr),
    .dma_we   (dma_we),
    .dma_din  (dma_din),
    .dma_ready(dma_ready),
    .dma_dout (dma_dout)
  );

  always #5 mclk = ~mclk;

  localparam logic [13:0] RB = 14'h00C8;  // 0x0190 byte -> word address
  localparam int R_CTRL = 0, R_STAT = 1, R_CNT = 2, R_LADDR = 3, R_LDATA = 4;

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t        per_q[$];
  logic [15:0] dma_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        rd_pend = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: DMA read data one cycle after acceptance, register data in the read cycle
  always @(negedge mclk) begin
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (dma_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL dma_rd_unexpected: got %h expected none", dma_dout);
      end else begin
        check("dma_rd", dma_dout, dma_q.pop_front());
      end
    end
    if (dma_en && dma_ready && (dma_we == 2'b00) && !puc_rst) rd_pend = 1'b1;
    if (per_en && (per_we == 2'b00)) begin
      if (per_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL per_rd_unexpected: got %h expected none", per_dout);
      end else begin
        exp_t e;
        e = per_q.pop_front();
        check(e.name, per_dout, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic per_wr(input int off, input logic [15:0] d, input logic [1:0] we);
    per_en = 1'b1; per_addr = RB + 14'(off); per_we = we; per_din = d;
    tick();
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic per_rd(input int off, input logic [15:0] e, input string n);
    exp_t it;
    it.name = n; it.val = e;
    per_q.push_back(it);
    per_en = 1'b1; per_addr = RB + 14'(off); per_we = 2'b00;
    tick();
    per_en = 1'b0;
  endtask

  task automatic dma_xfer(input logic [14:0] a, input logic [1:0] we, input logic [15:0] d,
                          input logic [15:0] exp_rd, input int max_cyc, output int cyc);
    logic rdy;
    rdy = 1'b0;
    cyc = 0;
    if (we == 2'b00) dma_q.push_back(exp_rd);
    dma_en = 1'b1; dma_addr = a; dma_we = we; dma_din = d;
    while (!rdy && cyc < max_cyc) begin
      @(negedge mclk);
      cyc++;
      rdy = dma_ready;
      @(posedge mclk);
      #1;
    end
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL dma_timeout: no ready after %0d cycles", cyc);
    end
    dma_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    logic got;
    puc_rst = 1'b1; per_en = 1'b0; per_we = 2'b00; per_addr = '0; per_din = '0;
    dma_en = 1'b0; dma_addr = '0; dma_we = 2'b00; dma_din = '0;
    repeat (3) tick();
    puc_rst = 1'b0;

    check("rst_dma_dout", dma_dout, 16'h0000);
    check("per_dout_idle", per_dout, 16'h0000);
    per_rd(R_CTRL,  16'h0000, "rst_ctrl");
    per_rd(R_STAT,  16'h0000, "rst_stat");
    per_rd(R_CNT,   16'h0000, "rst_cnt");
    per_rd(R_LADDR, 16'h0000, "rst_laddr");
    per_rd(R_LDATA, 16'h0000, "rst_ldata");

    // EN=1, WAIT=0: single-cycle write and read
    per_wr(R_CTRL, 16'h0001, 2'b11);
    per_rd(R_CTRL, 16'h0001, "ctrl_en");
    dma_xfer(15'h4000, 2'b11, 16'hBEEF, 16'h0000, 5, cyc);
    check("wr0_latency", 16'(cyc), 16'd1);
    per_rd(R_CNT,   16'd1,    "cnt_after_wr");
    per_rd(R_LADDR, 16'h8000, "laddr_after_wr");
    dma_xfer(15'h4000, 2'b00, 16'h0000, 16'hBEEF, 5, cyc);
    check("rd0_latency", 16'(cyc), 16'd1);

    // WAIT=3 held read: ready on 4th cycle, BUSY in cycles 2-4
    per_wr(R_CTRL, 16'h0031, 2'b01);
    dma_q.push_back(16'hBEEF);
    dma_en = 1'b1; dma_addr = 15'h4000; dma_we = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      if (k >= 2) begin
        exp_t it;
        it.name = "stat_busy"; it.val = 16'h0002;
        per_q.push_back(it);
        per_en = 1'b1; per_addr = RB + 14'(R_STAT); per_we = 2'b00;
      end
      @(negedge mclk);
      check("wait3_ready", {15'b0, dma_ready}, 16'(k == 4));
      @(posedge mclk);
      #1;
    end
    dma_en = 1'b0; per_en = 1'b0;
    per_rd(R_STAT, 16'h0000, "stat_idle");
    per_rd(R_CNT,  16'd3,    "cnt_after_wait");

    // Low-byte-only write
    per_wr(R_CTRL, 16'h0001, 2'b01);
    dma_xfer(15'h4000, 2'b01, 16'h1234, 16'h0000, 5, cyc);
    dma_xfer(15'h4000, 2'b00, 16'h0000, 16'hBE34, 5, cyc);

    // Out of range: word 0x5000 aliases index 0 if the range check were missing
    dma_xfer(15'h5000, 2'b11, 16'hFFFF, 16'h0000, 5, cyc);
    check("oor_wr_latency", 16'(cyc), 16'd1);
    per_rd(R_STAT,  16'h0001, "stat_oor");
    per_rd(R_CNT,   16'd6,    "cnt_after_oor");
    per_rd(R_LADDR, 16'hA000, "laddr_oor");
    dma_xfer(15'h4000, 2'b00, 16'h0000, 16'hBE34, 5, cyc);
    dma_xfer(15'h5000, 2'b00, 16'h0000, 16'h0000, 5, cyc);
    per_wr(R_STAT, 16'h0001, 2'b01);
    per_rd(R_STAT, 16'h0000, "stat_w1c");

    // Window boundaries: last word in range, first word past it
    dma_xfer(15'h403F, 2'b11, 16'hA5A5, 16'h0000, 5, cyc);
    dma_xfer(15'h403F, 2'b00, 16'h0000, 16'hA5A5, 5, cyc);
    dma_xfer(15'h4040, 2'b00, 16'h0000, 16'h0000, 5, cyc);
    per_rd(R_STAT, 16'h0001, "stat_oor_edge");
    per_rd(R_CNT,  16'd11,   "cnt_11");
    per_wr(R_STAT, 16'h0001, 2'b01);
    per_wr(R_CNT,  16'hFFFF, 2'b10);
    per_rd(R_CNT,  16'd0,    "cnt_clear");

    // EN=0 stalls the initiator, enabling lets it finish
    per_wr(R_CTRL, 16'h0000, 2'b01);
    dma_q.push_back(16'hBE34);
    dma_en = 1'b1; dma_addr = 15'h4000; dma_we = 2'b00;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      if (dma_ready) bad++;
      @(posedge mclk);
      #1;
    end
    check("en0_stall", 16'(bad), 16'd0);
    per_wr(R_CTRL, 16'h0001, 2'b01);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge mclk);
      got = dma_ready;
      @(posedge mclk);
      #1;
    end
    dma_en = 1'b0;
    check("en1_release", {15'b0, got}, 16'd1);
    per_rd(R_CNT, 16'd1, "cnt_after_release");

    // Reset during WAIT=5: no commit, registers cleared
    dma_xfer(15'h4001, 2'b11, 16'h1111, 16'h0000, 5, cyc);
    per_wr(R_CTRL, 16'h0051, 2'b01);
    dma_en = 1'b1; dma_addr = 15'h4001; dma_we = 2'b11; dma_din = 16'h7777;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge mclk);
      if (dma_ready) bad++;
      @(posedge mclk);
      #1;
    end
    check("wait5_no_early_ready", 16'(bad), 16'd0);
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    dma_en = 1'b0;
    check("rst_mid_dout", dma_dout, 16'h0000);
    per_rd(R_CTRL,  16'h0000, "rst2_ctrl");
    per_rd(R_STAT,  16'h0000, "rst2_stat");
    per_rd(R_CNT,   16'h0000, "rst2_cnt");
    per_rd(R_LADDR, 16'h0000, "rst2_laddr");
    per_wr(R_CTRL, 16'h0001, 2'b01);
    dma_xfer(15'h4001, 2'b00, 16'h0000, 16'h1111, 5, cyc);

    repeat (3) tick();
    check("dma_q_drained", 16'(dma_q.size()), 16'd0);
    check("per_q_drained", 16'(per_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
